risc_sequencer: RTL and testbench

- Control sequencer for the 8-bit Simple-RISC core.
- Produces the opcode-dependent control strobes that steer the ALU, accumulator, PC, instruction register and memory bus.
- Consumes the ALU's zero flag.
- Every instruction runs through a fixed 8-phase cycle, plus a sticky HALTED state.

---
 rtl/risc_sequencer.sv | 177 +++++++++++++++++
 tb/tb_risc_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/risc_sequencer.sv
// Simple-RISC control sequencer: 8-phase instruction cycle plus a sticky HALTED state.
// Optional single-step input is enabled by defining SIMPLE_RISC_STEP_EN.
module risc_sequencer #(
  parameter int OP_W        = 3,
  parameter int RESET_PHASE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
`ifdef SIMPLE_RISC_STEP_EN
  input  logic            step,
`endif
  input  logic [OP_W-1:0] opcode,
  input  logic            is_zero,
  output logic            sel,
  output logic            rd,
  output logic            ld_ir,
  output logic            inc_pc,
  output logic            ld_pc,
  output logic            ld_ac,
  output logic            wr,
  output logic            data_e,
  output logic            halt,
  output logic [2:0]      phase
);

  if (OP_W != 3) begin : g_bad_op_w
    $error("risc_sequencer: OP_W must be 3");
  end
  if (RESET_PHASE < 0 || RESET_PHASE > 7) begin : g_bad_reset_phase
    $error("risc_sequencer: RESET_PHASE must be 0..7");
  end

  typedef enum logic [3:0] {
    ST_INST_ADDR  = 4'd0,
    ST_INST_FETCH = 4'd1,
    ST_INST_LOAD  = 4'd2,
    ST_IDLE       = 4'd3,
    ST_OP_ADDR    = 4'd4,
    ST_OP_FETCH   = 4'd5,
    ST_ALU_OP     = 4'd6,
    ST_STORE      = 4'd7,
    ST_HALTED     = 4'd8
  } state_e;

  localparam logic [3:0] RESET_ST = 4'(RESET_PHASE);

  state_e state_r;
  state_e state_nxt_s;
  logic   zero_r;
  logic   adv_s;
  logic   op_ok_s;
  logic   is_alu_s;
  logic   is_hlt_s;
  logic   is_skz_s;
  logic   is_sto_s;
  logic   is_jmp_s;

`ifdef SIMPLE_RISC_STEP_EN
  assign adv_s = run | step;
`else
  assign adv_s = run;
`endif

  // Opcode class decode; anything unknown falls to default with every class low.
  always_comb begin
    op_ok_s  = 1'b0;
    is_alu_s = 1'b0;
    is_hlt_s = 1'b0;
    is_skz_s = 1'b0;
    is_sto_s = 1'b0;
    is_jmp_s = 1'b0;
    case (opcode)
      3'b000:                          begin op_ok_s = 1'b1; is_hlt_s = 1'b1; end
      3'b001:                          begin op_ok_s = 1'b1; is_skz_s = 1'b1; end
      3'b010, 3'b011, 3'b100, 3'b101:  begin op_ok_s = 1'b1; is_alu_s = 1'b1; end
      3'b110:                          begin op_ok_s = 1'b1; is_sto_s = 1'b1; end
      3'b111:                          begin op_ok_s = 1'b1; is_jmp_s = 1'b1; end
      default:                         begin op_ok_s = 1'b0; end
    endcase
  end

  // Next-state: HALTED is absorbing, otherwise wrap through the eight phases.
  always_comb begin
    state_nxt_s = state_r;
    if (state_r == ST_HALTED) begin
      state_nxt_s = ST_HALTED;
    end else if (adv_s) begin
      if (state_r == ST_OP_ADDR && is_hlt_s) begin
        state_nxt_s = ST_HALTED;
      end else begin
        state_nxt_s = state_e'({1'b0, state_r[2:0] + 3'd1});
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State register and zero-flag capture on the edge leaving IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= state_e'(RESET_ST);
      zero_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (adv_s && state_r == ST_IDLE) begin
        zero_r <= is_zero;
      end
    end
  end

  // Strobe decode from the registered phase and the live opcode.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    phase  = state_r[2:0];
    case (state_r)
      ST_INST_ADDR:  sel = 1'b1;
      ST_INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
      ST_INST_LOAD,
      ST_IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
      ST_OP_ADDR: begin
        inc_pc = op_ok_s & ~is_hlt_s;
        halt   = is_hlt_s;
      end
      ST_OP_FETCH:   rd = is_alu_s;
      ST_ALU_OP: begin
        rd     = is_alu_s;
        inc_pc = is_skz_s & zero_r;
        ld_pc  = is_jmp_s;
        data_e = is_sto_s;
      end
      ST_STORE: begin
        rd     = is_alu_s;
        ld_ac  = is_alu_s;
        ld_pc  = is_jmp_s;
        data_e = is_sto_s;
        wr     = is_sto_s;
      end
      ST_HALTED: begin
        halt  = 1'b1;
        phase = 3'd7;
      end
      default: phase = 3'd7;
    endcase
  end

  risc_sequencer_chk #(.OP_W(OP_W)) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_phase (state_r inside {ST_IDLE, ST_OP_ADDR, ST_OP_FETCH, ST_ALU_OP, ST_STORE}),
    .opcode   (opcode)
  );

endmodule

// Simulation checks: opcode must be known while it feeds the decode.
module risc_sequencer_chk #(
  parameter int OP_W = 3
) (
  input logic            clk,
  input logic            rst_n,
  input logic            op_phase,
  input logic [OP_W-1:0] opcode
);

  a_opcode_known: assert property (@(posedge clk) disable iff (!rst_n)
    op_phase |-> !$isunknown(opcode));

endmodule

// File: tb/tb_risc_sequencer.sv
// Directed bench for risc_sequencer: per-cycle vector table plus HLT, hold/reset and step sequences.
module tb_risc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [2:0] opcode;
  logic       is_zero;
`ifdef SIMPLE_RISC_STEP_EN
  logic       step;
`endif
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  risc_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
`ifdef SIMPLE_RISC_STEP_EN
    .step   (step),
`endif
    .opcode (opcode),
    .is_zero(is_zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  // strobe order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
  localparam logic [8:0] S_NONE  = 9'b000000000;
  localparam logic [8:0] S_F0    = 9'b100000000;
  localparam logic [8:0] S_F1    = 9'b110000000;
  localparam logic [8:0] S_F2    = 9'b111000000;
  localparam logic [8:0] S_INC   = 9'b000100000;
  localparam logic [8:0] S_RD    = 9'b010000000;
  localparam logic [8:0] S_RDLD  = 9'b010001000;
  localparam logic [8:0] S_DE    = 9'b000000010;
  localparam logic [8:0] S_WRDE  = 9'b000000110;
  localparam logic [8:0] S_LDPC  = 9'b000010000;
  localparam logic [8:0] S_HALT  = 9'b000000001;

  typedef struct {
    logic       run;
    logic [2:0] op;
    logic       z;
    logic [2:0] ph;
    logic [8:0] st;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [11:0] obs();
    return {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got phase=%0d strobes=%b, want phase=%0d strobes=%b",
               name, act[11:9], act[8:0], exp[11:9], exp[8:0]);
    end
  endtask

  task automatic add(input logic r, input logic [2:0] op, input logic z,
                     input logic [2:0] ph, input logic [8:0] st);
    vecs.push_back('{run: r, op: op, z: z, ph: ph, st: st});
  endtask

  task automatic add_fetch(input logic [2:0] op, input logic z_other, input logic z3);
    add(1'b1, op, z_other, 3'd0, S_F0);
    add(1'b1, op, z_other, 3'd1, S_F1);
    add(1'b1, op, z_other, 3'd2, S_F2);
    add(1'b1, op, z3,      3'd3, S_F2);
  endtask

  initial begin
    rst_n   = 1'b0;
    run     = 1'b0;
    opcode  = 3'b000;
    is_zero = 1'b0;
`ifdef SIMPLE_RISC_STEP_EN
    step    = 1'b0;
`endif

    // ADD, with a one-cycle run=0 hold in phase 5
    add_fetch(3'b010, 1'b0, 1'b0);
    add(1'b1, 3'b010, 1'b0, 3'd4, S_INC);
    add(1'b0, 3'b010, 1'b0, 3'd5, S_RD);
    add(1'b1, 3'b010, 1'b0, 3'd5, S_RD);
    add(1'b1, 3'b010, 1'b0, 3'd6, S_RD);
    add(1'b1, 3'b010, 1'b0, 3'd7, S_RDLD);
    // STO
    add_fetch(3'b110, 1'b0, 1'b0);
    add(1'b1, 3'b110, 1'b0, 3'd4, S_INC);
    add(1'b1, 3'b110, 1'b0, 3'd5, S_NONE);
    add(1'b1, 3'b110, 1'b0, 3'd6, S_DE);
    add(1'b1, 3'b110, 1'b0, 3'd7, S_WRDE);
    // JMP
    add_fetch(3'b111, 1'b0, 1'b0);
    add(1'b1, 3'b111, 1'b0, 3'd4, S_INC);
    add(1'b1, 3'b111, 1'b0, 3'd5, S_NONE);
    add(1'b1, 3'b111, 1'b0, 3'd6, S_LDPC);
    add(1'b1, 3'b111, 1'b0, 3'd7, S_LDPC);
    // SKZ, zero at the phase-3 exit edge: skip
    add_fetch(3'b001, 1'b0, 1'b1);
    add(1'b1, 3'b001, 1'b0, 3'd4, S_INC);
    add(1'b1, 3'b001, 1'b0, 3'd5, S_NONE);
    add(1'b1, 3'b001, 1'b0, 3'd6, S_INC);
    add(1'b1, 3'b001, 1'b0, 3'd7, S_NONE);
    // SKZ, zero everywhere except that edge: no skip
    add_fetch(3'b001, 1'b1, 1'b0);
    add(1'b1, 3'b001, 1'b1, 3'd4, S_INC);
    add(1'b1, 3'b001, 1'b1, 3'd5, S_NONE);
    add(1'b1, 3'b001, 1'b1, 3'd6, S_NONE);
    add(1'b1, 3'b001, 1'b1, 3'd7, S_NONE);

    #12;
    check("reset", obs(), {3'd0, S_F0});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run     = vecs[i].run;
      opcode  = vecs[i].op;
      is_zero = vecs[i].z;
      #1;
      check($sformatf("vec%0d", i), obs(), {vecs[i].ph, vecs[i].st});
      @(negedge clk);
    end

    // HLT: halt in phase 4 without inc_pc, then sticky HALTED
    opcode  = 3'b000;
    run     = 1'b1;
    is_zero = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("hlt_phase4", obs(), {3'd4, S_HALT});
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      run    = i[0];
      opcode = 3'($urandom_range(7, 0));
      #1;
      check($sformatf("halted%0d", i), obs(), {3'd7, S_HALT});
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("halt_reset", obs(), {3'd0, S_F0});
    @(negedge clk);
    rst_n = 1'b1;

    // STO held in phase 7, then asynchronous reset mid-hold
    opcode = 3'b110;
    run    = 1'b1;
    repeat (7) @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("sto_hold%0d", i), obs(), {3'd7, S_WRDE});
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("sto_abort", obs(), {3'd0, S_F0});
    @(negedge clk);
    rst_n = 1'b1;

`ifdef SIMPLE_RISC_STEP_EN
    run    = 1'b0;
    opcode = 3'b010;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      @(negedge clk);
    end
    step = 1'b0;
    #1;
    check("step3", obs(), {3'd3, S_F2});
    repeat (3) @(negedge clk);
    #1;
    check("step_hold", obs(), {3'd3, S_F2});
`else
    run = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("run0_hold", obs(), {3'd0, S_F0});
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
